// File: rtl/sbox6_sweep_checker.sv
// rtl/sbox6_sweep_checker.sv - exhaustive 6-bit S-box sweep: bijectivity, output XOR, fixed points
// Optional SBOX6_DDT_EN adds one differential-distribution-table entry count after the sweep.
module sbox6_sweep_checker #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] sbox_x,
    input  logic [N-1:0] sbox_y,
    output logic         busy,
    output logic         done,
    output logic         bijective,
    output logic [N-1:0] xor_sum,
    output logic [N:0]   fixed_points
`ifdef SBOX6_DDT_EN
    ,
    input  logic [N-1:0] ddt_delta,
    input  logic [N-1:0] ddt_out,
    output logic [N:0]   ddt_count
`endif
);

    localparam logic [N-1:0] X_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DDT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [N-1:0]       sbox_x_q;
    logic               busy_q;
    logic               done_q;
    logic               bijective_q;
    logic [N-1:0]       xor_sum_q;
    logic [N:0]         fixed_points_q;
    logic [2**N-1:0]    seen_q;
    logic [2**N-1:0]    seen_d;

`ifdef SBOX6_DDT_EN
    logic [N-1:0]       hold_q;
    logic [N-1:0]       delta_q;
    logic [N-1:0]       out_q;
    logic [N-1:0]       ddt_x_q;
    logic               phase_q;
    logic [N:0]         ddt_count_q;
`endif

    // Bitmap including the response being sampled this cycle, so the last
    // sample participates in the bijectivity reduction.
    always_comb begin
        seen_d         = seen_q;
        seen_d[sbox_y] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            sbox_x_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            bijective_q    <= 1'b0;
            xor_sum_q      <= '0;
            fixed_points_q <= '0;
            seen_q         <= '0;
`ifdef SBOX6_DDT_EN
            hold_q         <= '0;
            delta_q        <= '0;
            out_q          <= '0;
            ddt_x_q        <= '0;
            phase_q        <= 1'b0;
            ddt_count_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seen_q         <= '0;
                        xor_sum_q      <= '0;
                        fixed_points_q <= '0;
                        bijective_q    <= 1'b0;
`ifdef SBOX6_DDT_EN
                        ddt_count_q    <= '0;
`endif
                        sbox_x_q       <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    seen_q    <= seen_d;
                    xor_sum_q <= xor_sum_q ^ sbox_y;
                    if (sbox_y == sbox_x_q) begin
                        fixed_points_q <= fixed_points_q + 1'b1;
                    end
                    sbox_x_q <= sbox_x_q + 1'b1;
                    if (sbox_x_q == X_LAST) begin
                        bijective_q <= &seen_d;
`ifdef SBOX6_DDT_EN
                        delta_q <= ddt_delta;
                        out_q   <= ddt_out;
                        ddt_x_q <= '0;
                        phase_q <= 1'b0;
                        state_q <= S_DDT;
`else
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef SBOX6_DDT_EN
                S_DDT: begin
                    if (!phase_q) begin
                        hold_q   <= sbox_y;
                        sbox_x_q <= ddt_x_q ^ delta_q;
                        phase_q  <= 1'b1;
                    end else begin
                        if ((hold_q ^ sbox_y) == out_q) begin
                            ddt_count_q <= ddt_count_q + 1'b1;
                        end
                        phase_q  <= 1'b0;
                        ddt_x_q  <= ddt_x_q + 1'b1;
                        sbox_x_q <= ddt_x_q + 1'b1;
                        if (ddt_x_q == X_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sbox_x       = sbox_x_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bijective    = bijective_q;
    assign xor_sum      = xor_sum_q;
    assign fixed_points = fixed_points_q;
`ifdef SBOX6_DDT_EN
    assign ddt_count    = ddt_count_q;
`endif

endmodule

// File: tb/tb_sbox6_sweep_checker.sv
// tb/tb_sbox6_sweep_checker.sv - self-checking bench for sbox6_sweep_checker (default and SBOX6_DDT_EN builds)
module tb_sbox6_sweep_checker;

`ifdef SBOX6_DDT_EN
    localparam int LAT = 192;
`else
    localparam int LAT = 64;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] sbox_x;
    logic [5:0] sbox_y;
    logic       busy;
    logic       done;
    logic       bijective;
    logic [5:0] xor_sum;
    logic [6:0] fixed_points;
`ifdef SBOX6_DDT_EN
    logic [5:0] ddt_delta;
    logic [5:0] ddt_out;
    logic [6:0] ddt_count;
`endif

    logic [5:0] lut [64];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sbox_y = lut[sbox_x];

    sbox6_sweep_checker #(.N(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sbox_x(sbox_x),
        .sbox_y(sbox_y),
        .busy(busy),
        .done(done),
        .bijective(bijective),
        .xor_sum(xor_sum),
        .fixed_points(fixed_points)
`ifdef SBOX6_DDT_EN
        ,
        .ddt_delta(ddt_delta),
        .ddt_out(ddt_out),
        .ddt_count(ddt_count)
`endif
    );

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r = 6'd0;
        logic [5:0] aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [5:0] gf_pow40(input logic [5:0] x);
        logic [5:0] r = 6'd1;
        for (int i = 0; i < 40; i++) r = gf_mul(r, x);
        return r;
    endfunction

    task automatic model(input int a, input int b, output bit bij, output logic [5:0] xs,
                         output int fp, output int dc);
        bit seen [64];
        bij = 1'b1; xs = 6'd0; fp = 0; dc = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int x = 0; x < 64; x++) begin
            if (seen[lut[x]]) bij = 1'b0;
            seen[lut[x]] = 1'b1;
            xs = xs ^ lut[x];
            if (int'(lut[x]) == x) fp++;
            if (int'(lut[x] ^ lut[x ^ a]) == b) dc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input int a, input int b, output int done_at, output int busy_err,
                          output int pulses);
`ifdef SBOX6_DDT_EN
        ddt_delta = 6'(a);
        ddt_out   = 6'(b);
`endif
        done_at = -1; busy_err = 0; pulses = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= LAT + 10; k++) begin
            if (k > 0) step();
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (busy !== (k < LAT)) busy_err++;
        end
`ifndef SBOX6_DDT_EN
        if (a != b) busy_err = busy_err + 0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        step(); step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (sbox_x !== 6'd0) begin failures++;
            $display("FAIL reset_x got=%0d expected 0", sbox_x); end
        checks++; if (bijective !== 1'b0 || xor_sum !== 6'd0 || fixed_points !== 7'd0) begin failures++;
            $display("FAIL reset_results bij=%b xor=%0d fp=%0d expected 0 0 0", bijective, xor_sum, fixed_points); end
`ifdef SBOX6_DDT_EN
        checks++; if (ddt_count !== 7'd0) begin failures++;
            $display("FAIL reset_ddt got=%0d expected 0", ddt_count); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sbox(input string name, input int a, input int b);
        int done_at, busy_err, pulses, fp, dc;
        bit bij;
        logic [5:0] xs;
        model(a, b, bij, xs, fp, dc);
        do_run(a, b, done_at, busy_err, pulses);
        checks++; if (done_at != LAT || pulses != 1) begin failures++;
            $display("FAIL %s_done at=%0d pulses=%0d expected at=%0d pulses=1", name, done_at, pulses, LAT); end
        checks++; if (busy_err != 0) begin failures++;
            $display("FAIL %s_busy bad_cycles=%0d expected 0", name, busy_err); end
        checks++; if (bijective !== bij) begin failures++;
            $display("FAIL %s_bijective got=%b expected %b", name, bijective, bij); end
        checks++; if (xor_sum !== xs) begin failures++;
            $display("FAIL %s_xor got=%0d expected %0d", name, xor_sum, xs); end
        checks++; if (fixed_points !== 7'(fp)) begin failures++;
            $display("FAIL %s_fixed got=%0d expected %0d", name, fixed_points, fp); end
`ifdef SBOX6_DDT_EN
        checks++; if (ddt_count !== 7'(dc)) begin failures++;
            $display("FAIL %s_ddt got=%0d expected %0d", name, ddt_count, dc); end
`endif
    endtask

    task automatic test_identity();
        for (int i = 0; i < 64; i++) lut[i] = 6'(i);
        test_sbox("identity", 3, 3);
        checks++; if (bijective !== 1'b1 || xor_sum !== 6'd0 || fixed_points !== 7'd64) begin failures++;
            $display("FAIL identity_const bij=%b xor=%0d fp=%0d expected 1 0 64", bijective, xor_sum, fixed_points); end
`ifdef SBOX6_DDT_EN
        checks++; if (ddt_count !== 7'd64) begin failures++;
            $display("FAIL identity_ddt33 got=%0d expected 64", ddt_count); end
`endif
    endtask

    task automatic test_constant();
        for (int i = 0; i < 64; i++) lut[i] = 6'h05;
        test_sbox("constant", 1, 0);
        checks++; if (bijective !== 1'b0 || xor_sum !== 6'd0 || fixed_points !== 7'd1) begin failures++;
            $display("FAIL constant_const bij=%b xor=%0d fp=%0d expected 0 0 1", bijective, xor_sum, fixed_points); end
    endtask

    task automatic test_power40();
        for (int i = 0; i < 64; i++) lut[i] = gf_pow40(6'(i));
        test_sbox("pow40", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        checks++; if (bijective !== 1'b1 || xor_sum !== 6'd0) begin failures++;
            $display("FAIL pow40_const bij=%b xor=%0d expected 1 0", bijective, xor_sum); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            if (it[0]) begin
                for (int i = 0; i < 64; i++) lut[i] = 6'(i);
                for (int i = 63; i > 0; i--) begin
                    int j;
                    logic [5:0] t;
                    j = int'($urandom_range(0, i));
                    t = lut[i]; lut[i] = lut[j]; lut[j] = t;
                end
            end else begin
                for (int i = 0; i < 64; i++) lut[i] = 6'($urandom);
            end
            test_sbox("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end
    endtask

`ifdef SBOX6_DDT_EN
    task automatic test_ddt();
        int done_at, busy_err, pulses;
        for (int i = 0; i < 64; i++) lut[i] = 6'(i);
        do_run(3, 4, done_at, busy_err, pulses);
        checks++; if (ddt_count !== 7'd0) begin failures++;
            $display("FAIL ddt_a3_b4 got=%0d expected 0", ddt_count); end
        do_run(0, 0, done_at, busy_err, pulses);
        checks++; if (ddt_count !== 7'd64) begin failures++;
            $display("FAIL ddt_a0_b0 got=%0d expected 64", ddt_count); end
        do_run(0, 5, done_at, busy_err, pulses);
        checks++; if (ddt_count !== 7'd0) begin failures++;
            $display("FAIL ddt_a0_b5 got=%0d expected 0", ddt_count); end
    endtask
`endif

    task automatic test_reset_midrun();
        int spurious;
        for (int i = 0; i < 64; i++) lut[i] = 6'(i);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 30; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sbox_x !== 6'd0) begin failures++;
            $display("FAIL midreset_ctrl busy=%b done=%b x=%0d expected 0 0 0", busy, done, sbox_x); end
        checks++; if (bijective !== 1'b0 || xor_sum !== 6'd0 || fixed_points !== 7'd0) begin failures++;
            $display("FAIL midreset_results bij=%b xor=%0d fp=%0d expected 0 0 0", bijective, xor_sum, fixed_points); end
        spurious = 0;
        for (int k = 0; k < LAT + 20; k++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin failures++;
            $display("FAIL midreset_quiet active_cycles=%0d expected 0", spurious); end
        test_sbox("after_reset", 2, 7);
    endtask

    task automatic test_start_held();
        int exp_q[$];
        int obs_q[$];
        int t, last;
        for (int i = 0; i < 64; i++) lut[i] = 6'(i);
        t = 0;
        forever begin
            exp_q.push_back(t + LAT);
            if (t + LAT + 2 <= 69) t = t + LAT + 2;
            else break;
        end
        last = exp_q[exp_q.size() - 1];
`ifdef SBOX6_DDT_EN
        ddt_delta = 6'd1; ddt_out = 6'd1;
`endif
        start = 1'b1;
        step();
        for (int k = 0; k <= last + 10; k++) begin
            if (k > 0) step();
            if (done === 1'b1) obs_q.push_back(k);
            if (k == 69) start = 1'b0;
        end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++;
            $display("FAIL held_pulses got=%0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] != exp_q[i]) begin failures++;
                $display("FAIL held_done_at[%0d] got=%0d expected %0d", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 64; i++) lut[i] = 6'h3f;
        for (int k = 0; k < 20; k++) step();
        checks++; if (fixed_points !== 7'd64 || bijective !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL held_results_hold fp=%0d bij=%b busy=%b expected 64 1 0", fixed_points, bijective, busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
`ifdef SBOX6_DDT_EN
        ddt_delta = 6'd0;
        ddt_out   = 6'd0;
`endif
        for (int i = 0; i < 64; i++) lut[i] = 6'(i);
        step();
        test_reset();
        test_identity();
        test_constant();
        test_power40();
        test_random();
`ifdef SBOX6_DDT_EN
        test_ddt();
`endif
        test_reset_midrun();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
